// File: rtl/n_term_cfg_switch_matrix_if.sv
// North-to-south wire bundle plus serial configuration strobes for n_term_cfg_switch_matrix.
// slave is the switch-matrix view; master is the driver/observer view.
interface n_term_cfg_switch_matrix_if #(
  parameter int N1W = 4,
  parameter int N2W = 8,
  parameter int N4W = 16
);
  logic [N1W-1:0] N1END;
  logic [N2W-1:0] N2MID;
  logic [N2W-1:0] N2END;
  logic [N4W-1:0] N4END;
  logic [N4W-1:0] NN4END;
  logic [N1W-1:0] S1BEG;
  logic [N2W-1:0] S2BEG;
  logic [N2W-1:0] S2BEGb;
  logic [N4W-1:0] S4BEG;
  logic [N4W-1:0] SS4BEG;
  logic           CONF_DATA;
  logic           CONF_EN;
  logic           CONF_LATCH;
  logic           CONF_DONE;
  logic           CONF_ERR;

  modport slave (
    input  N1END, N2MID, N2END, N4END, NN4END, CONF_DATA, CONF_EN, CONF_LATCH,
    output S1BEG, S2BEG, S2BEGb, S4BEG, SS4BEG, CONF_DONE, CONF_ERR
  );

  modport master (
    output N1END, N2MID, N2END, N4END, NN4END, CONF_DATA, CONF_EN, CONF_LATCH,
    input  S1BEG, S2BEG, S2BEGb, S4BEG, SS4BEG, CONF_DONE, CONF_ERR
  );
endinterface

// File: rtl/n_term_cfg_switch_matrix.sv
// Five-group north-to-south switch matrix with serially loaded 2-bit modes per group.
// Optional feature macro: N_TERM_SM_ACT_CNT_EN adds the ACT_CNT output-activity counter.
module n_term_cfg_switch_matrix #(
  parameter int N1W     = 4,
  parameter int N2W     = 8,
  parameter int N4W     = 16,
  parameter bit REG_OUT = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  n_term_cfg_switch_matrix_if.slave sw
`ifdef N_TERM_SM_ACT_CNT_EN
  ,
  output logic [15:0] ACT_CNT
`endif
);

  localparam int SW = N1W + 2 * N2W + 2 * N4W;

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic [3:0]      cnt_next;
  logic [9:0]      sr_reg;
  logic [4:0][1:0] mode_reg;
  logic            err_reg;
  logic            done_reg;
  logic            commit;

  logic [N1W-1:0]  s1_comb;
  logic [N2W-1:0]  s2_comb;
  logic [N2W-1:0]  s2b_comb;
  logic [N4W-1:0]  s4_comb;
  logic [N4W-1:0]  ss4_comb;
  logic [SW-1:0]   south_comb;
  logic [SW-1:0]   south_out;

  function automatic logic pick(input logic [1:0] mode, input logic rev_bit, input logic str_bit);
    logic r;
    case (mode)
      2'b00:   r = rev_bit;
      2'b01:   r = str_bit;
      2'b10:   r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign cnt_next = (cnt_reg == 4'd15) ? cnt_reg : cnt_reg + 4'd1;
  // FULL is exactly "ten bits shifted since the last latch"
  assign commit   = sw.CONF_LATCH && (state_reg == FULL);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      sr_reg    <= 10'd0;
      mode_reg  <= '0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (sw.CONF_LATCH) begin
        cnt_reg   <= 4'd0;
        state_reg <= IDLE;
        if (state_reg == FULL) begin
          mode_reg <= sr_reg;
          err_reg  <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          err_reg  <= 1'b1;
        end
      end else if (sw.CONF_EN) begin
        sr_reg    <= {sr_reg[8:0], sw.CONF_DATA};
        cnt_reg   <= cnt_next;
        state_reg <= (cnt_next == 4'd10) ? FULL : ((cnt_next > 4'd10) ? OVER : SHIFT);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N1W; gi++) begin : g_s1
      assign s1_comb[gi] = pick(mode_reg[0], sw.N1END[N1W-1-gi], sw.N1END[gi]);
    end
    for (gi = 0; gi < N2W; gi++) begin : g_s2
      assign s2_comb[gi]  = pick(mode_reg[1], sw.N2MID[N2W-1-gi], sw.N2MID[gi]);
      assign s2b_comb[gi] = pick(mode_reg[2], sw.N2END[N2W-1-gi], sw.N2END[gi]);
    end
    for (gi = 0; gi < N4W; gi++) begin : g_s4
      assign s4_comb[gi]  = pick(mode_reg[3], sw.N4END[N4W-1-gi], sw.N4END[gi]);
      assign ss4_comb[gi] = pick(mode_reg[4], sw.NN4END[N4W-1-gi], sw.NN4END[gi]);
    end
  endgenerate

  assign south_comb = {s1_comb, s2_comb, s2b_comb, s4_comb, ss4_comb};

  generate
    if (REG_OUT) begin : g_reg_out
      logic [SW-1:0] south_reg;
      always_ff @(posedge CLK) begin
        if (RESET) south_reg <= '0;
        else       south_reg <= south_comb;
      end
      assign south_out = south_reg;
    end else begin : g_comb_out
      assign south_out = south_comb;
    end
  endgenerate

  assign {sw.S1BEG, sw.S2BEG, sw.S2BEGb, sw.S4BEG, sw.SS4BEG} = south_out;
  assign sw.CONF_DONE = done_reg;
  assign sw.CONF_ERR  = err_reg;

`ifdef N_TERM_SM_ACT_CNT_EN
  logic [SW-1:0] prev_reg;
  logic [15:0]   act_cnt_reg;

  // Counts cycles where the visible south outputs moved relative to the cycle before.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_reg    <= '0;
      act_cnt_reg <= 16'd0;
    end else begin
      prev_reg <= south_out;
      if (commit)
        act_cnt_reg <= 16'd0;
      else if ((south_out != prev_reg) && (act_cnt_reg != 16'hFFFF))
        act_cnt_reg <= act_cnt_reg + 16'd1;
    end
  end

  assign ACT_CNT = act_cnt_reg;
`endif

endmodule

// File: doc/n_term_cfg_switch_matrix.md
N_TERM_CFG_SWITCH_MATRIX -- requirements
Module: n_term_cfg_switch_matrix

Interface
REQ-001 Parameter N1W, default 4, SHALL set the single-hop wire count.
REQ-002 Parameter N2W, default 8, SHALL set the double-hop wire count for both MID and END.
REQ-003 Parameter N4W, default 16, SHALL set the quad-hop wire count for both N4 and NN4.
REQ-004 Parameter REG_OUT, default 0, SHALL add a registered output stage when 1.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 N1END  in  N1W; N2MID  in  N2W; N2END  in  N2W; N4END  in  N4W; NN4END  in  N4W: arriving north wires.
REQ-008 S1BEG  out  N1W; S2BEG  out  N2W; S2BEGb  out  N2W; S4BEG  out  N4W; SS4BEG  out  N4W: departing south wires.
REQ-009 CONF_DATA  in  1  serial configuration bit.
REQ-010 CONF_EN  in  1  shift strobe, one bit per cycle.
REQ-011 CONF_LATCH  in  1  single-cycle commit request.
REQ-012 CONF_DONE  out  1  one-cycle pulse on successful commit.
REQ-013 CONF_ERR  out  1  sticky frame-length error flag.

Function
REQ-014 Groups SHALL be g0 S1BEG<-N1END, g1 S2BEG<-N2MID, g2 S2BEGb<-N2END, g3 S4BEG<-N4END, g4 SS4BEG<-NN4END.
REQ-015 Each group SHALL have a 2-bit active mode: 00 reverse out[i]=in[W-1-i]; 01 straight out[i]=in[i]; 10 all 0; 11 all 1.
REQ-016 A 10-bit shadow register SR SHALL shift SR<={SR[8:0],CONF_DATA} on each cycle with CONF_EN=1 and CONF_LATCH=0.
REQ-017 Field placement SHALL be SR[1:0]=g0, [3:2]=g1, [5:4]=g2, [7:6]=g3, [9:8]=g4; the first bit shifted lands in SR[9].
REQ-018 A 4-bit shift counter SHALL increment per shift and saturate at 15.
REQ-019 A CONF_LATCH cycle with counter==10 SHALL load active modes from SR at that edge, clear CONF_ERR, and pulse CONF_DONE the next cycle.
REQ-020 A CONF_LATCH cycle with counter!=10 SHALL leave active modes unchanged, set CONF_ERR, and not pulse CONF_DONE.
REQ-021 Every CONF_LATCH SHALL clear the counter; SR SHALL be retained.
REQ-022 CONF_LATCH and CONF_EN together SHALL give priority to the latch; that shift SHALL be discarded.
REQ-023 Mode changes SHALL take effect on outputs in the cycle after the committing edge when REG_OUT=0, and one cycle later when REG_OUT=1.
REQ-024 REG_OUT=0 SHALL make the outputs combinational from inputs with zero latency; REG_OUT=1 SHALL add exactly one cycle of latency.
REQ-025 Control FSM states SHALL be IDLE (counter 0), SHIFT (0<counter<10), FULL (counter==10) and OVER (counter>10); CONF_LATCH from any state SHALL return to IDLE.

Reset
REQ-026 RESET SHALL set all active modes to 00 (reverse), SR to 0, counter to 0, CONF_ERR to 0, CONF_DONE to 0 and registered outputs to 0.
REQ-027 RESET asserted mid-shift or in the same cycle as CONF_LATCH SHALL win; no commit SHALL occur.

Configuration
REQ-028 Macro N_TERM_SM_ACT_CNT_EN defined SHALL add output ACT_CNT[15:0], counting cycles in which any south output bit differs from the previous cycle.
REQ-029 ACT_CNT SHALL saturate at 16'hFFFF and SHALL clear on RESET and on each successful commit.
REQ-030 Without N_TERM_SM_ACT_CNT_EN, the ACT_CNT port and its logic SHALL be absent.

Verification
REQ-031 Release RESET, N1END=4'b0001, N4END=16'h0001 -> S1BEG=4'b1000, S4BEG=16'h8000.
REQ-032 Shift 10 bits giving SR=10'b01_01_01_01_01, then latch -> CONF_DONE high for 1 cycle; N2MID=8'h01 -> S2BEG=8'h01.
REQ-033 Shift 7 bits, then latch -> CONF_ERR=1, modes unchanged, no CONF_DONE; a following valid 10-bit load and latch -> CONF_ERR=0.
REQ-034 CONF_EN and CONF_LATCH high together on the 11th cycle after 10 shifts -> commit succeeds using the first 10 bits.
REQ-035 REG_OUT=1, g4 mode 11 committed -> SS4BEG=16'hFFFF two cycles after the latch edge; RESET the next cycle -> SS4BEG=0 and modes back to reverse.
REQ-036 N_TERM_SM_ACT_CNT_EN defined, N1END toggled 5 times -> ACT_CNT=5; successful commit -> ACT_CNT=0.
